// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in, program memory write port out
interface prog_loader_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [7:0]  waddr_o;
  logic [15:0] wdata_o;

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, we_o, waddr_o, wdata_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to 256x16 program memory loader
// Frame: A5, COUNT (0 = 256 words), {HI, LO} per word, CSUM over COUNT and payload.
module prog_loader (
  input  logic         clk_i,
  input  logic         rst_ni,
  prog_loader_if.slave bus,
  output logic         busy_o,
  output logic         cpu_halt_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [7:0]  waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  hi_q, hi_d;
  logic        accept;

  assign accept = bus.byte_valid_i && ready_q;

  always_comb begin
    state_d = state_q;
    ready_d = 1'b1;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (accept && bus.byte_i == 8'hA5) begin
          state_d = S_COUNT;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          sum_d   = 8'h00;
          addr_d  = 8'h00;
        end
      end
      S_COUNT: begin
        if (accept) begin
          rem_d   = (bus.byte_i == 8'h00) ? 9'd256 : {1'b0, bus.byte_i};
          sum_d   = bus.byte_i;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = bus.byte_i;
          sum_d   = sum_q + bus.byte_i;
          state_d = S_LO;
        end
      end
      S_LO: begin
        // The write cycle doubles as the ready bubble, so no byte lands during it.
        if (accept) begin
          sum_d   = sum_q + bus.byte_i;
          we_d    = 1'b1;
          ready_d = 1'b0;
          waddr_d = addr_q;
          wdata_d = {hi_q, bus.byte_i};
          addr_d  = addr_q + 8'd1;
          rem_d   = rem_q - 9'd1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = (rem_q == 9'd0) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        if (accept) begin
          if (bus.byte_i == sum_q) done_d = 1'b1;
          else                     err_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 8'h00;
      wdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= 8'h00;
      addr_q  <= 8'h00;
      rem_q   <= 9'd0;
      hi_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign bus.we_o         = we_q;
  assign bus.waddr_o      = waddr_q;
  assign bus.wdata_o      = wdata_q;
  assign busy_o           = busy_q;
  assign cpu_halt_o       = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus ();
  logic busy, halt, done, err;

  prog_loader dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .bus        (bus),
    .busy_o     (busy),
    .cpu_halt_o (halt),
    .done_o     (done),
    .err_o      (err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q[$];
  logic [15:0] words[256];
  int done_seen = 0;
  int done_exp = 0;
  logic rst_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected write for every we_o and checks protocol invariants.
  always @(posedge clk) rst_s <= rst_ni;

  always @(negedge clk) begin
    logic [23:0] e;
    check("halt_eq_busy", {31'd0, halt}, {31'd0, busy});
    if (rst_s) check("ready_not_we", {31'd0, bus.byte_ready_o}, {31'd0, !bus.we_o});
    if (done) done_seen++;
    if (bus.we_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.waddr_o, bus.wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("write", {8'd0, bus.waddr_o, bus.wdata_o}, {8'd0, e});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      bus.byte_valid_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.byte_i = b;
    bus.byte_valid_i = 1'b1;
    t = 0;
    while (!bus.byte_ready_o && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.byte_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference: expected writes are simply (i, words[i]); checksum is plain modular sum.
  task automatic run_frame(input int n, input int csum_delta, input int maxgap, input int rst_after);
    logic [7:0] sum;
    logic [7:0] nb;
    logic [7:0] csum;
    logic [7:0] ia;
    logic good;
    nb = n[7:0];
    sum = nb;
    for (int i = 0; i < n; i++) begin
      sum = sum + words[i][15:8] + words[i][7:0];
      ia = i[7:0];
      if (rst_after < 0 || i < rst_after) exp_q.push_back({ia, words[i]});
    end
    csum = sum + csum_delta[7:0];
    good = (csum_delta == 0);
    send_byte(8'hA5, $urandom_range(maxgap, 0));
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    check("err_clear_on_sync", {31'd0, err}, 32'd0);
    send_byte(nb, $urandom_range(maxgap, 0));
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8], $urandom_range(maxgap, 0));
      send_byte(words[i][7:0], $urandom_range(maxgap, 0));
      check("we_latency", {31'd0, bus.we_o}, 32'd1);
      check("ready_bubble", {31'd0, bus.byte_ready_o}, 32'd0);
      if (rst_after == i + 1) begin
        rst_ni = 1'b0;
        bus.byte_valid_i = 1'b0;
        @(posedge clk); #1;
        check("rst_outputs", {bus.byte_ready_o, bus.we_o, busy, halt, done, err},  32'd0);
        check("rst_addr_data", {8'd0, bus.waddr_o, bus.wdata_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, bus.byte_ready_o}, 32'd1);
        check("busy_after_rst", {31'd0, busy}, 32'd0);
        check("err_after_rst", {31'd0, err}, 32'd0);
        return;
      end
    end
    send_byte(csum, $urandom_range(maxgap, 0));
    bus.byte_valid_i = 1'b0;
    check("busy_after_csum", {31'd0, busy}, 32'd0);
    check("done_pulse", {31'd0, done}, {31'd0, good});
    check("err_flag", {31'd0, err}, {31'd0, !good});
    if (good) done_exp++;
  endtask

  initial begin
    bus.byte_i = 8'h00;
    bus.byte_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {bus.byte_ready_o, bus.we_o, busy, halt, done, err}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", {31'd0, bus.byte_ready_o}, 32'd1);

    words[0] = 16'h1234; words[1] = 16'hABCD;
    run_frame(2, 0, 0, -1);
    idle(3);

    run_frame(2, 1, 0, -1);
    idle(5);
    check("err_sticky", {31'd0, err}, 32'd1);

    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    idle(2);
    check("garbage_ignored", {31'd0, busy}, 32'd0);
    words[0] = 16'hA55A;
    run_frame(1, 0, 0, -1);
    idle(3);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = i[7:0];
      words[i] = {iv, ~iv};
    end
    run_frame(256, 0, 0, -1);
    idle(6);

    for (int i = 0; i < 5; i++) words[i] = 16'($urandom);
    run_frame(5, 0, 0, 3);
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    run_frame(4, 0, 2, -1);
    idle(3);

    for (int r = 0; r < 3; r++) begin
      words[0] = 16'h1234; words[1] = 16'hABCD;
      run_frame(2, 0, 5, -1);
      idle(2);
    end

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      run_frame(n, ($urandom_range(3, 0) == 0) ? $urandom_range(255, 1) : 0, 3, -1);
      idle($urandom_range(3, 0));
    end

    idle(10);
    check("no_pending_writes", exp_q.size(), 32'd0);
    check("done_count", done_seen, done_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
